// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and helpers for the mux select sequencer.
// State encoding, channel-count defaults and mask scan functions.
package muxseq_pkg;

  localparam int NCH_DEF   = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Lowest enabled channel of a mask (0 when empty)
  function automatic logic [SEL_W_DEF-1:0] lo_ch(
    input logic [NCH_DEF-1:0] m
  );
    lo_ch = '0;
    for (int i = NCH_DEF - 1; i >= 0; i--) begin
      if (m[i]) lo_ch = SEL_W_DEF'(i);
    end
  endfunction

  // Highest enabled channel of a mask (0 when empty)
  function automatic logic [SEL_W_DEF-1:0] hi_ch(
    input logic [NCH_DEF-1:0] m
  );
    hi_ch = '0;
    for (int i = 0; i < NCH_DEF; i++) begin
      if (m[i]) hi_ch = SEL_W_DEF'(i);
    end
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
// master drives START/STOP/MASK/DWELL; slave returns the select stream.
interface mux_sel_sequencer_if
  import muxseq_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = 8
);

  logic               START;
  logic               STOP;
  logic [NCH-1:0]     MASK;
  logic [DWELL_W-1:0] DWELL;
  logic [SEL_W-1:0]   S;
  logic               S_VALID;
  logic               FRAME_DONE;
  logic               BUSY;

  modport master (
    output START,
    output STOP,
    output MASK,
    output DWELL,
    input  S,
    input  S_VALID,
    input  FRAME_DONE,
    input  BUSY
  );

  modport slave (
    input  START,
    input  STOP,
    input  MASK,
    input  DWELL,
    output S,
    output S_VALID,
    output FRAME_DONE,
    output BUSY
  );

endinterface

// File: rtl/mux_sel_sequencer_next_ch.sv
// Next enabled channel above cur, wrapping to the lowest one.
// last is set when cur is the highest enabled channel.
module muxseq_next_ch
  import muxseq_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             last
);

  // Descending scan so the nearest enabled channel above cur wins
  always_comb begin
    nxt  = lo_ch(mask);
    last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        nxt  = SEL_W'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the 4:1 data mux: dwell-timed channel scan.
// Build option MUXSEQ_ONESHOT_EN: stop after one frame instead of looping.
module mux_sel_sequencer
  import muxseq_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = 8
) (
  input logic                CLK,
  input logic                RST_N,
  mux_sel_sequencer_if.slave bus
);

`ifdef MUXSEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  state_t             state;
  logic [NCH-1:0]     mask_q;
  logic [DWELL_W-1:0] d_m1_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [SEL_W-1:0]   hi_q;
  logic [SEL_W-1:0]   s_q;
  logic               s_valid_q;
  logic               fd_q;
  logic               busy_q;

  logic [SEL_W-1:0]   nxt_ch;
  logic               last_ch;
  logic [DWELL_W-1:0] d_in_m1;
  logic [SEL_W-1:0]   lo_in;
  logic [SEL_W-1:0]   hi_in;
  logic               go;

  // Dwell of 0 behaves as 1, so the reload value is max(DWELL,1)-1
  assign d_in_m1 = (bus.DWELL == '0) ? '0
                 : bus.DWELL - DWELL_W'(1);
  assign lo_in   = lo_ch(bus.MASK);
  assign hi_in   = hi_ch(bus.MASK);
  assign go      = bus.START && !bus.STOP
                && (bus.MASK != '0);

  muxseq_next_ch #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask (mask_q),
    .cur  (s_q),
    .nxt  (nxt_ch),
    .last (last_ch)
  );

  // Scan FSM; FRAME_DONE is precomputed for the cycle being entered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      d_m1_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_SCAN;
            mask_q    <= bus.MASK;
            d_m1_q    <= d_in_m1;
            cnt_q     <= d_in_m1;
            hi_q      <= hi_in;
            s_q       <= lo_in;
            s_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            fd_q      <= (d_in_m1 == '0)
                      && (lo_in == hi_in);
          end
        end
        ST_SCAN: begin
          if (bus.STOP) begin
            state     <= ST_IDLE;
            s_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
            fd_q  <= (cnt_q == DWELL_W'(1))
                  && last_ch;
          end else if (ONESHOT && last_ch) begin
            state     <= ST_IDLE;
            s_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
          end else begin
            s_q   <= nxt_ch;
            cnt_q <= d_m1_q;
            fd_q  <= (d_m1_q == '0)
                  && (nxt_ch == hi_q);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.S          = s_q;
  assign bus.S_VALID    = s_valid_q;
  assign bus.FRAME_DONE = fd_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomised bench for mux_sel_sequencer against a frame-time model.
// Expected outputs come from elapsed time since START and the channel list.
module tb_mux_sel_sequencer;

`ifdef MUXSEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mux_sel_sequencer_if bus ();

  mux_sel_sequencer dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel list, dwell and cycles since START
  bit act;
  int lst[4];
  int n_en;
  int dw_m;
  int t;
  int exp_s;
  bit exp_fd;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".s"}, 32'(bus.S), 32'(exp_s));
    chk({tag, ".vld"}, 32'(bus.S_VALID), 32'(act));
    chk({tag, ".busy"}, 32'(bus.BUSY), 32'(act));
    chk({tag, ".fd"}, 32'(bus.FRAME_DONE),
        32'(exp_fd));
  endtask

  task automatic model_reset();
    act    = 1'b0;
    exp_s  = 0;
    exp_fd = 1'b0;
    t      = 0;
  endtask

  task automatic model_edge(
    input logic       st,
    input logic       sp,
    input logic [3:0] m,
    input logic [7:0] dw
  );
    if (!act) begin
      if (st && !sp && m != 4'd0) begin
        n_en = 0;
        for (int c = 0; c < 4; c++) begin
          if (m[c]) begin
            lst[n_en] = c;
            n_en++;
          end
        end
        dw_m  = (dw == 8'd0) ? 1 : int'(dw);
        t     = 0;
        act   = 1'b1;
        exp_s = lst[0];
      end
    end else if (sp) begin
      act = 1'b0;
    end else begin
      t++;
      if (ONESHOT && t >= n_en * dw_m) act = 1'b0;
      else exp_s = lst[(t / dw_m) % n_en];
    end
    exp_fd = act
          && (t % (n_en * dw_m) == n_en * dw_m - 1);
  endtask

  // One clock: drive, let the edge happen, update model, check at +1
  task automatic tick(
    input string      tag,
    input logic       st,
    input logic       sp,
    input logic [3:0] m,
    input logic [7:0] dw
  );
    bus.START = st;
    bus.STOP  = sp;
    bus.MASK  = m;
    bus.DWELL = dw;
    @(posedge clk);
    model_edge(st, sp, m, dw);
    #1;
    chk_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(tag, 1'b0, 1'b0,
           4'($urandom_range(0, 15)),
           8'($urandom));
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.MASK  = 4'd0;
    bus.DWELL = 8'd0;
    rst_n     = 1'b0;
    model_reset();
    #2;
    chk_all("rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick("idle", 1'b0, 1'b0, 4'hf, 8'd3);

    // Full mask, dwell 3, then async reset mid-scan
    tick("m1111", 1'b1, 1'b0, 4'hf, 8'd3);
    run("m1111", 30);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("rst_mid");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick("post_rst", 1'b0, 1'b0, 4'hf, 8'd3);
    tick("post_rst", 1'b0, 1'b0, 4'h5, 8'd1);

    // Alternating 1/3 with dwell 0
    tick("m1010", 1'b1, 1'b0, 4'ha, 8'd0);
    run("m1010", 8);
    tick("m1010.stop", 1'b0, 1'b1, 4'ha, 8'd0);

    // Empty mask is ignored
    tick("m0000", 1'b1, 1'b0, 4'h0, 8'd2);
    tick("m0000", 1'b1, 1'b0, 4'h0, 8'd2);

    // Single channel 2, dwell 2
    tick("m0100", 1'b1, 1'b0, 4'h4, 8'd2);
    run("m0100", 9);
    tick("m0100.stop", 1'b0, 1'b1, 4'h4, 8'd2);

    // STOP together with START
    tick("stst", 1'b1, 1'b1, 4'hf, 8'd1);
    tick("stst", 1'b0, 1'b0, 4'hf, 8'd1);

    // STOP sampled where the frame-end pulse would begin
    tick("sfd", 1'b1, 1'b0, 4'hf, 8'd3);
    run("sfd", 10);
    tick("sfd.stop", 1'b0, 1'b1, 4'hf, 8'd3);
    tick("sfd.idle", 1'b0, 1'b0, 4'hf, 8'd3);

    // STOP during the frame-end cycle itself
    tick("sfd2", 1'b1, 1'b0, 4'h6, 8'd2);
    run("sfd2", 3);
    tick("sfd2.stop", 1'b0, 1'b1, 4'h6, 8'd2);
    tick("sfd2.idle", 1'b0, 1'b0, 4'h6, 8'd2);

    // Maximum dwell on one channel
    tick("dmax", 1'b1, 1'b0, 4'h1, 8'hff);
    run("dmax", 520);
    tick("dmax.stop", 1'b0, 1'b1, 4'h1, 8'hff);

    // Random sessions with stray START/STOP and mask/dwell churn
    for (int seg = 0; seg < 40; seg++) begin
      automatic int len = $urandom_range(1, 45);
      automatic logic [7:0] d0 =
        ($urandom_range(0, 7) == 0)
          ? 8'($urandom) : 8'($urandom_range(0, 4));
      tick("rnd.go", 1'b1,
           ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)), d0);
      for (int i = 0; i < len; i++) begin
        tick("rnd", ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 29) == 0),
             4'($urandom_range(0, 15)),
             8'($urandom_range(0, 4)));
      end
      tick("rnd.stop", 1'b0, 1'b1, 4'hf, 8'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
